umi_sram_target: RTL and testbench

//  UMI request target that consumes the 256-bit UMI request stream produced by the
//  CPU-side AXI-to-UMI bridge (umi1 data channel) and returns responses to it.

---
 rtl/umi_sram_target.sv | 162 ++++++++++++++++
 tb/tb_umi_sram_target.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_sram_target.sv
// UMI request target backed by a word-addressed single-port SRAM model.
// One request in flight: IDLE (accept) -> ACCESS (SRAM cycle) -> RESP (response handshake).
module umi_sram_target #(
    parameter int UW    = 256,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [UW-1:0] umi_out_packet,
    input  logic          umi_out_ready,
    output logic          busy,
    output logic [15:0]   err_count
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = DW / 8;

    localparam logic [7:0] RD_REQ   = 8'h01;
    localparam logic [7:0] WR_REQ   = 8'h03;
    localparam logic [7:0] RD_RESP  = 8'h02;
    localparam logic [7:0] WR_ACK   = 8'h04;
    localparam logic [7:0] ERR_RESP = 8'h0F;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] src_q, src_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] strb_q, strb_d;
    logic [15:0]   err_count_q, err_count_d;
    logic [DW-1:0] rdata_q;

    logic [DW-1:0] mem [DEPTH];

    logic          in_fire;
    logic          out_fire;
    logic          is_rd;
    logic          is_wr;
    logic          in_range;
    logic          resp_err;
    logic [IW-1:0] word_idx;
    logic [7:0]    resp_cmd;
    logic [DW-1:0] resp_data;
    logic          unused_in;

    assign umi_in_ready  = (state_q == IDLE) & nreset;
    assign umi_out_valid = (state_q == RESP);
    assign busy          = (state_q != IDLE);
    assign err_count     = err_count_q;

    assign in_fire  = umi_in_valid & umi_in_ready;
    assign out_fire = umi_out_valid & umi_out_ready;

    assign is_rd    = (cmd_q == RD_REQ);
    assign is_wr    = (cmd_q == WR_REQ);
    assign in_range = (dst_q[AW-1:IW+2] == '0);
    assign word_idx = dst_q[IW+1:2];
    assign resp_err = ~(is_rd | is_wr) | ~in_range;

    // Only the fixed fields of the request are meaningful; the rest is don't-care.
    assign unused_in = ^umi_in_packet;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        dst_d       = dst_q;
        src_d       = src_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = ACCESS;
                    cmd_d   = umi_in_packet[7:0];
                    dst_d   = umi_in_packet[AW+31:32];
                    src_d   = umi_in_packet[AW+95:96];
                    wdata_d = umi_in_packet[DW+127:128];
                    strb_d  = umi_in_packet[SW+159:160];
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                if (out_fire) begin
                    state_d = IDLE;
                    if (resp_err && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: the SRAM array has no reset; its contents survive nreset like real memory.
    always_ff @(posedge clk) begin
        if ((state_q == ACCESS) && nreset) begin
            if (is_wr && in_range) begin
                for (int b = 0; b < SW; b++) begin
                    if (strb_q[b]) begin
                        mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
            rdata_q <= mem[word_idx];
        end
    end

    always_comb begin
        resp_cmd = ERR_RESP;
        if (is_rd) begin
            resp_cmd = RD_RESP;
        end else if (is_wr) begin
            resp_cmd = WR_ACK;
        end
        resp_data = (is_rd && in_range) ? rdata_q : '0;

        // Response addresses are swapped so it routes back to the requester.
        umi_out_packet = '0;
        if (state_q == RESP) begin
            umi_out_packet[7:0]        = resp_cmd;
            umi_out_packet[8]          = resp_err;
            umi_out_packet[AW+31:32]   = src_q;
            umi_out_packet[AW+95:96]   = dst_q;
            umi_out_packet[DW+127:128] = resp_data;
        end
    end

endmodule

// File: tb/tb_umi_sram_target.sv
// Bench for umi_sram_target: directed cases plus random traffic against a
// behavioural memory model, with a queue-based scoreboard and an independent monitor.
module tb_umi_sram_target;
    localparam int UW    = 256;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4096;
    localparam int IW    = $clog2(DEPTH);

    localparam logic [7:0] RD_REQ   = 8'h01;
    localparam logic [7:0] WR_REQ   = 8'h03;
    localparam logic [7:0] RD_RESP  = 8'h02;
    localparam logic [7:0] WR_ACK   = 8'h04;
    localparam logic [7:0] ERR_RESP = 8'h0F;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          umi_in_valid = 1'b0;
    logic [UW-1:0] umi_in_packet = '0;
    logic          umi_in_ready;
    logic          umi_out_valid;
    logic [UW-1:0] umi_out_packet;
    logic          umi_out_ready;
    logic          busy;
    logic [15:0]   err_count;

    int n_checks   = 0;
    int n_fail     = 0;
    int n_resp     = 0;
    int n_push     = 0;
    int model_err  = 0;
    int ready_mode = 0;  // 0: ready high, 1: ready low, 2: random

    logic [UW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    umi_sram_target #(
        .UW(UW), .AW(AW), .DW(DW), .DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .umi_in_valid   (umi_in_valid),
        .umi_in_packet  (umi_in_packet),
        .umi_in_ready   (umi_in_ready),
        .umi_out_valid  (umi_out_valid),
        .umi_out_packet (umi_out_packet),
        .umi_out_ready  (umi_out_ready),
        .busy           (busy),
        .err_count      (err_count)
    );

    task automatic check(input string name, input logic [UW-1:0] act, input logic [UW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, expected normal handshake", name);
    endtask

    function automatic logic [UW-1:0] make_pkt(input logic [7:0] cmd, input logic err,
                                               input logic [AW-1:0] dst, input logic [AW-1:0] src,
                                               input logic [DW-1:0] data, input logic [3:0] strb);
        logic [UW-1:0] p;
        p = '0;
        p[7:0]     = cmd;
        p[8]       = err;
        p[63:32]   = dst;
        p[127:96]  = src;
        p[159:128] = data;
        p[163:160] = strb;
        return p;
    endfunction

    // Reference model: applies the request to the model memory and queues the response.
    function automatic void model_accept(input logic [7:0] cmd, input logic [AW-1:0] dst,
                                         input logic [AW-1:0] src, input logic [DW-1:0] data,
                                         input logic [3:0] strb);
        bit            inr;
        logic [IW-1:0] widx;
        logic [7:0]    rcmd;
        logic          rerr;
        logic [DW-1:0] rdata;
        inr   = (dst >> 2) < 32'(DEPTH);
        widx  = dst[IW+1:2];
        rdata = '0;
        if (cmd == RD_REQ) begin
            rcmd = RD_RESP;
            rerr = !inr;
            if (inr) rdata = model_mem[widx];
        end else if (cmd == WR_REQ) begin
            rcmd = WR_ACK;
            rerr = !inr;
            if (inr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[widx][8*b +: 8] = data[8*b +: 8];
                end
            end
        end else begin
            rcmd = ERR_RESP;
            rerr = 1'b1;
        end
        exp_q.push_back(make_pkt(rcmd, rerr, src, dst, rdata, 4'h0));
        n_push++;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] cmd, input logic [AW-1:0] dst, input logic [AW-1:0] src,
                        input logic [DW-1:0] data, input logic [3:0] strb, input bit track);
        logic [UW-1:0] pkt;
        logic [95:0]   junk;
        bit            ok;
        ok   = 1'b0;
        junk = {$urandom, $urandom, $urandom};
        pkt  = make_pkt(cmd, 1'b0, dst, src, data, strb);
        pkt[UW-1:164] = junk[91:0];
        umi_in_packet = pkt;
        umi_in_valid  = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (umi_in_ready) begin
                ok = 1'b1;
                if (track) model_accept(cmd, dst, src, data, strb);
            end
            @(posedge clk);
            #1;
        end
        umi_in_valid = 1'b0;
        if (!ok) fail_note("accept_timeout");
    endtask

    // Directed response check right after send(), with out_ready held high.
    task automatic check_resp(input string name, input logic [7:0] cmd, input logic err,
                              input logic [DW-1:0] data);
        @(negedge clk);
        check({name, "_no_valid_in_access"}, UW'(umi_out_valid), UW'(0));
        @(negedge clk);
        check({name, "_valid"}, UW'(umi_out_valid), UW'(1));
        check({name, "_cmd"}, UW'(umi_out_packet[7:0]), UW'(cmd));
        check({name, "_err"}, UW'(umi_out_packet[8]), UW'(err));
        check({name, "_data"}, UW'(umi_out_packet[159:128]), UW'(data));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || busy) && i < 400) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain_queue_empty", UW'(exp_q.size()), UW'(0));
        check("drain_not_busy", UW'(busy), UW'(0));
    endtask

    initial begin
        umi_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       umi_out_ready = 1'b1;
                1:       umi_out_ready = 1'b0;
                default: umi_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every presented response must match the queue head and stay put until taken.
    initial begin
        forever begin
            @(negedge clk);
            if (nreset && umi_out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_note("unexpected_response");
                end else begin
                    check("resp_packet", umi_out_packet, exp_q[0]);
                    if (umi_out_ready) begin
                        if (exp_q[0][8] && model_err < 65535) model_err++;
                        void'(exp_q.pop_front());
                        n_resp++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        ready_mode = 0;
        nreset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_in_ready", UW'(umi_in_ready), UW'(0));
        check("reset_out_valid", UW'(umi_out_valid), UW'(0));
        check("reset_out_packet", umi_out_packet, UW'(0));
        check("reset_busy", UW'(busy), UW'(0));
        check("reset_err_count", UW'(err_count), UW'(0));
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", UW'(umi_in_ready), UW'(1));
        @(posedge clk);
        #1;

        // T1 / T2: write, read back, partial-strobe write
        send(WR_REQ, 32'h10, 32'h5000, 32'hDEADBEEF, 4'hF, 1'b1);
        check_resp("t1_wr", WR_ACK, 1'b0, 32'h0);
        wait_idle();
        send(RD_REQ, 32'h10, 32'h5004, 32'h0, 4'h0, 1'b1);
        check_resp("t2_rd", RD_RESP, 1'b0, 32'hDEADBEEF);
        wait_idle();
        send(WR_REQ, 32'h10, 32'h5008, 32'h0000AA00, 4'h2, 1'b1);
        check_resp("t2_wr_strb", WR_ACK, 1'b0, 32'h0);
        wait_idle();
        send(RD_REQ, 32'h13, 32'h500C, 32'h0, 4'h0, 1'b1);
        check_resp("t2_rd_strb", RD_RESP, 1'b0, 32'hDEADAAEF);
        wait_idle();

        // T3: out-of-range read and unknown command
        send(RD_REQ, 32'(4 * DEPTH), 32'h5010, 32'h0, 4'h0, 1'b1);
        check_resp("t3_oor", RD_RESP, 1'b1, 32'h0);
        wait_idle();
        check("t3_err_count_1", UW'(err_count), UW'(1));
        send(8'h55, 32'h10, 32'h5014, 32'h0, 4'h0, 1'b1);
        check_resp("t3_unknown", ERR_RESP, 1'b1, 32'h0);
        wait_idle();
        check("t3_err_count_2", UW'(err_count), UW'(2));

        // T4: response backpressure with a second request waiting
        ready_mode = 1;
        send(RD_REQ, 32'h10, 32'h6000, 32'h0, 4'h0, 1'b1);
        umi_in_packet = make_pkt(WR_REQ, 1'b0, 32'h20, 32'h6004, 32'h12345678, 4'hF);
        umi_in_valid  = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_in_ready_low", UW'(umi_in_ready), UW'(0));
            check("t4_out_valid_held", UW'(umi_out_valid), UW'(1));
            @(posedge clk);
            #1;
        end
        ready_mode = 0;
        base = n_resp;
        send(WR_REQ, 32'h20, 32'h6004, 32'h12345678, 4'hF, 1'b1);
        wait_idle();
        check("t4_response_count", UW'(n_resp - base), UW'(2));

        // T5: reset during ACCESS drops the request
        send(RD_REQ, 32'h10, 32'h7000, 32'h0, 4'h0, 1'b0);
        nreset = 1'b0;
        @(negedge clk);
        check("t5_in_ready_in_reset", UW'(umi_in_ready), UW'(0));
        @(posedge clk);
        #1;
        nreset    = 1'b1;
        model_err = 0;
        @(negedge clk);
        check("t5_in_ready_after", UW'(umi_in_ready), UW'(1));
        check("t5_err_count_cleared", UW'(err_count), UW'(0));
        for (int i = 0; i < 3; i++) begin
            check("t5_no_response", UW'(umi_out_valid), UW'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        send(RD_REQ, 32'h10, 32'h7004, 32'h0, 4'h0, 1'b1);
        check_resp("t5_next_rd", RD_RESP, 1'b0, 32'hDEADAAEF);
        wait_idle();

        // T6: random traffic over a prefilled working set plus the top word
        for (int w = 0; w <= 16; w++) begin
            int word;
            word = (w == 16) ? DEPTH - 1 : w;
            send(WR_REQ, AW'(word * 4), 32'h8000, $urandom, 4'hF, 1'b1);
        end
        wait_idle();
        ready_mode = 2;
        base = n_resp;
        for (int k = 0; k < 100; k++) begin
            int            sel;
            int            word;
            logic [AW-1:0] a;
            logic [7:0]    c;
            sel  = int'($urandom_range(0, 99));
            word = int'($urandom_range(0, 16));
            if (word == 16) word = DEPTH - 1;
            a = AW'(word * 4 + int'($urandom_range(0, 3)));
            if (sel < 45) begin
                c = WR_REQ;
            end else if (sel < 90) begin
                c = RD_REQ;
            end else if (sel < 95) begin
                c = ($urandom_range(0, 1) == 1) ? RD_REQ : WR_REQ;
                if ($urandom_range(0, 1) == 1) a = AW'((DEPTH + int'($urandom_range(0, 1000))) * 4);
                else a = 32'h8000_0000 | $urandom;
            end else begin
                case ($urandom_range(0, 3))
                    0:       c = 8'h00;
                    1:       c = 8'h55;
                    2:       c = 8'hFF;
                    default: c = RD_RESP;
                endcase
            end
            send(c, a, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'b1);
        end
        wait_idle();
        ready_mode = 0;
        check("t6_response_count", UW'(n_resp - base), UW'(100));
        check("total_push_vs_resp", UW'(n_resp), UW'(n_push));
        check("final_err_count", UW'(err_count), UW'(model_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
